// File: rtl/mux_4x1.sv
// -----------------------------------------------------------------------------
// mux_4x1
//
// Purpose:
//   Four-lane, one-output selector. It is the leaf cell of the mux tree: four
//   first-level cells share addr[1:0] and a fifth cell uses addr[3:2] to build
//   a 16:1 mux. The primary function is the combinational output `out`. Users
//   that need a pipeline stage can take `out_q`, a registered copy with an
//   enable.
//
// Parameters:
//   WIDTH   bits per input lane (the tree uses WIDTH = 1)
//
// Ports:
//   clk     in   1         system clock, used only by out_q
//   rst_n   in   1         asynchronous active-low reset, clears out_q
//   en      in   1         capture enable for out_q
//   addr    in   2         lane select
//   muxIns  in   4*WIDTH   packed lanes, lane k = muxIns[k*WIDTH +: WIDTH]
//   out     out  WIDTH     combinational selected lane
//   out_q   out  WIDTH     selected lane registered one clock later
// -----------------------------------------------------------------------------
module mux_4x1 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         addr,
  input  logic [4*WIDTH-1:0] muxIns,
  output logic [WIDTH-1:0]   out,
  output logic [WIDTH-1:0]   out_q
);

  logic [WIDTH-1:0] lane0;
  logic [WIDTH-1:0] lane1;
  logic [WIDTH-1:0] lane2;
  logic [WIDTH-1:0] lane3;
  logic [WIDTH-1:0] out_d;

  assign lane0 = muxIns[0*WIDTH +: WIDTH];
  assign lane1 = muxIns[1*WIDTH +: WIDTH];
  assign lane2 = muxIns[2*WIDTH +: WIDTH];
  assign lane3 = muxIns[3*WIDTH +: WIDTH];

  // Nested conditional operators, not a case statement. When a select bit is
  // X/Z, the conditional operator merges both arms bit by bit: a bit is known
  // only if every candidate lane agrees on it. Unselected lanes are never
  // reached when addr is known, so their glitches or X values cannot reach
  // the output. No priority between the lanes is implied.
  assign out = addr[1] ? (addr[0] ? lane3 : lane2)
                       : (addr[0] ? lane1 : lane0);

  assign out_d = en ? out : out_q;

  // Registered copy. Reset is asynchronous and only clears out_q. Releasing
  // reset does not capture; the first capture happens on the next rising edge
  // with en high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

endmodule

// File: tb/tb_mux_4x1.sv
module tb_mux_4x1;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  addr;
  logic [3:0]  mux_ins;
  logic [0:0]  out_w1;
  logic [0:0]  outq_w1;

  logic        en8;
  logic [1:0]  addr8;
  logic [31:0] ins8;
  logic [7:0]  out_w8;
  logic [7:0]  outq_w8;

  logic [15:0] ins16;
  logic [3:0]  addr4;
  logic [3:0]  lvl1;
  logic [3:0]  lvl1_q;
  logic [0:0]  tree_out;
  logic [0:0]  tree_q;

  int n_cmp;
  int n_bad;

  mux_4x1 #(.WIDTH(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .addr(addr),
    .muxIns(mux_ins), .out(out_w1), .out_q(outq_w1)
  );

  mux_4x1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .addr(addr8),
    .muxIns(ins8), .out(out_w8), .out_q(outq_w8)
  );

  // 16:1 tree: four first-level cells on addr4[1:0], final cell on addr4[3:2].
  for (genvar g = 0; g < 4; g++) begin : g_lvl1
    mux_4x1 #(.WIDTH(1)) u_leaf (
      .clk(clk), .rst_n(rst_n), .en(1'b1), .addr(addr4[1:0]),
      .muxIns(ins16[g*4 +: 4]), .out(lvl1[g]), .out_q(lvl1_q[g])
    );
  end

  mux_4x1 #(.WIDTH(1)) u_root (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .addr(addr4[3:2]),
    .muxIns(lvl1), .out(tree_out), .out_q(tree_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: selected lane computed by shifting the packed word.
  function automatic logic [7:0] ref_sel(input logic [31:0] lanes, input int a, input int w);
    logic [31:0] sh;
    logic [7:0]  mask;
    sh   = lanes >> (a * w);
    mask = (w == 8) ? 8'hFF : 8'h01;
    return sh[7:0] & mask;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] model_q;
  logic       exp_bit;

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    en      = 1'b0;
    addr    = 2'd0;
    mux_ins = 4'h0;
    en8     = 1'b0;
    addr8   = 2'd0;
    ins8    = 32'h0;
    ins16   = 16'h0;
    addr4   = 4'h0;

    #3;
    check("reset_outq_w1", 32'(outq_w1), 32'h0);
    check("reset_outq_w8", 32'(outq_w8), 32'h0);
    tick();
    check("reset_hold_outq", 32'(outq_w1), 32'h0);

    // Exhaustive combinational sweep, WIDTH=1.
    for (int v = 0; v < 64; v++) begin
      mux_ins = v[5:2];
      addr    = v[1:0];
      #10;
      check("exhaustive", 32'(out_w1), 32'(ref_sel(32'(v[5:2]), v & 3, 1)));
    end

    mux_ins = 4'b0100; addr = 2'd2; #10;
    check("ex_0100_a2", 32'(out_w1), 32'h1);
    addr = 2'd1; #10;
    check("ex_0100_a1", 32'(out_w1), 32'h0);

    // Lane isolation.
    addr = 2'd3;
    for (int v = 0; v < 8; v++) begin
      mux_ins = {1'b1, v[2:0]};
      #10;
      check("isolation", 32'(out_w1), 32'h1);
    end

    // Random combinational patterns.
    for (int i = 0; i < 100; i++) begin
      mux_ins = 4'($urandom);
      addr    = 2'($urandom);
      #7;
      check("rand_comb", 32'(out_w1), 32'(ref_sel(32'(mux_ins), int'(addr), 1)));
    end

    // 16:1 tree.
    ins16 = 16'h8000; addr4 = 4'd15; #10;
    check("tree_8000_a15", 32'(tree_out), 32'h1);
    addr4 = 4'd14; #10;
    check("tree_8000_a14", 32'(tree_out), 32'h0);
    for (int i = 0; i < 400; i++) begin
      ins16 = 16'($urandom);
      addr4 = 4'($urandom);
      #3;
      check("tree_rand", 32'(tree_out), 32'((ins16 >> addr4) & 16'h1));
    end

    // Reset: capture 1, assert reset between edges, release, first capture.
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; mux_ins = 4'b0010; addr = 2'd1;
    tick();
    check("capture_one", 32'(outq_w1), 32'h1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", 32'(outq_w1), 32'h0);
    tick();
    check("reset_held", 32'(outq_w1), 32'h0);
    check("out_ignores_rst", 32'(out_w1), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_no_capture", 32'(outq_w1), 32'h0);
    tick();
    check("first_capture", 32'(outq_w1), 32'h1);

    // Enable hold.
    @(negedge clk);
    en = 1'b0; mux_ins = 4'b0000;
    #1;
    check("hold_out_comb", 32'(out_w1), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_outq", 32'(outq_w1), 32'h1);
    end
    @(negedge clk);
    en = 1'b1;
    tick();
    check("reenable", 32'(outq_w1), 32'h0);

    // Random registered behaviour against a one-deep scoreboard.
    model_q = 8'(outq_w1);
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      mux_ins = 4'($urandom);
      addr    = 2'($urandom);
      en      = 1'($urandom);
      exp_bit = mux_ins[addr];
      if (en) model_q = {7'd0, exp_bit};
      tick();
      check("rand_outq", 32'(outq_w1), 32'(model_q));
    end

    // WIDTH=8.
    ins8 = {8'h44, 8'h33, 8'h22, 8'h11};
    en8  = 1'b1;
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      addr8 = 2'(a);
      #1;
      check("w8_out", 32'(out_w8), 32'(8'h11 * (a + 1)));
      tick();
      check("w8_outq", 32'(outq_w8), 32'(8'h11 * (a + 1)));
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ins8  = $urandom;
      addr8 = 2'($urandom);
      #1;
      check("w8_rand", 32'(out_w8), 32'(ref_sel(ins8, int'(addr8), 8)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
